// File: rtl/psum_gbf_drain.sv
// rtl/psum_gbf_drain.sv - drains one psum global buffer bank to a valid/ready stream, then zero-initialises it
module psum_gbf_drain #(
    parameter int PSUM_GBF_DATA_BITWIDTH = 512,
    parameter int PSUM_GBF_ADDR_BITWIDTH = 5,
    parameter int PSUM_GBF_DEPTH         = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              drain_start,
    input  logic                              drain_bank,
    input  logic [PSUM_GBF_ADDR_BITWIDTH:0]   drain_len,
    output logic                              busy,
    output logic                              done,
    output logic                              psum_gbf_r_en,
    output logic [PSUM_GBF_ADDR_BITWIDTH-1:0] psum_gbf_r_addr,
    output logic                              psum_gbf_r_num,
    input  logic [PSUM_GBF_DATA_BITWIDTH-1:0] r_data1b,
    input  logic [PSUM_GBF_DATA_BITWIDTH-1:0] r_data2b,
    output logic                              psum_gbf_w_en_for_init,
    output logic [PSUM_GBF_ADDR_BITWIDTH-1:0] psum_gbf_w_addr_for_init,
    output logic                              m_valid,
    output logic [PSUM_GBF_DATA_BITWIDTH-1:0] m_data,
    output logic                              m_last,
    input  logic                              m_ready
);
    localparam int DW = PSUM_GBF_DATA_BITWIDTH;
    localparam int AW = PSUM_GBF_ADDR_BITWIDTH;
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(PSUM_GBF_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_INIT, S_FLUSH} state_t;

    state_t          state_q, state_d;
    logic            bank_q, bank_d;
    logic [LW-1:0]   len_q, len_d;
    logic [LW-1:0]   rd_cnt_q, rd_cnt_d;
    logic [LW-1:0]   init_cnt_q, init_cnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    // rvalid marks a read whose data is on r_data this cycle; rlast tags it as the final entry
    logic            rvalid_q, rvalid_d;
    logic            rlast_q, rlast_d;
    logic [DW-1:0]   fifo_data_q [2];
    logic [DW-1:0]   fifo_data_d [2];
    logic [1:0]      fifo_last_q, fifo_last_d;
    logic            wr_ptr_q, wr_ptr_d;
    logic            rd_ptr_q, rd_ptr_d;
    logic [1:0]      count_q, count_d;

    logic            pop;
    logic            rd_issue;
    logic            credit_ok;
    logic            last_rd;
    logic            last_init;
    logic [2:0]      occ;
    logic [LW-1:0]   len_clamped;

    // A read may issue only if the FIFO can still hold it once everything in flight lands
    assign pop         = (count_q != 2'd0) && m_ready;
    assign occ         = 3'(count_q) + 3'(rvalid_q) - 3'(pop);
    assign credit_ok   = occ < 3'd2;
    assign len_clamped = (drain_len > DEPTH_L) ? DEPTH_L : drain_len;
    assign last_rd     = rd_cnt_q == (len_q - LW'(1));
    assign last_init   = init_cnt_q == (len_q - LW'(1));

    assign busy                     = busy_q;
    assign done                     = done_q;
    assign psum_gbf_r_en            = rd_issue;
    assign psum_gbf_r_addr          = rd_cnt_q[AW-1:0];
    assign psum_gbf_r_num           = bank_q;
    assign psum_gbf_w_en_for_init   = (state_q == S_INIT);
    assign psum_gbf_w_addr_for_init = init_cnt_q[AW-1:0];
    assign m_valid                  = (count_q != 2'd0);
    assign m_data                   = fifo_data_q[rd_ptr_q];
    assign m_last                   = m_valid && fifo_last_q[rd_ptr_q];

    // Next-state: drain sequencing, read issue under credit, and the 2-entry output FIFO
    always_comb begin
        state_d     = state_q;
        bank_d      = bank_q;
        len_d       = len_q;
        rd_cnt_d    = rd_cnt_q;
        init_cnt_d  = init_cnt_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        rd_issue    = 1'b0;
        fifo_data_d = fifo_data_q;
        fifo_last_d = fifo_last_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;

        case (state_q)
            S_IDLE: begin
                if (drain_start) begin
                    bank_d     = drain_bank;
                    len_d      = len_clamped;
                    rd_cnt_d   = '0;
                    init_cnt_d = '0;
                    busy_d     = 1'b1;
                    state_d    = (len_clamped == '0) ? S_FLUSH : S_READ;
                end
            end
            S_READ: begin
                if (credit_ok) begin
                    rd_issue = 1'b1;
                    rd_cnt_d = rd_cnt_q + LW'(1);
                    if (last_rd) begin
                        state_d = S_INIT;
                    end
                end
            end
            S_INIT: begin
                init_cnt_d = init_cnt_q + LW'(1);
                if (last_init) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if ((count_q == 2'd0) && !rvalid_q) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        rvalid_d = rd_issue;
        rlast_d  = rd_issue && last_rd;

        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        if (rvalid_q) begin
            fifo_data_d[wr_ptr_q] = bank_q ? r_data2b : r_data1b;
            fifo_last_d[wr_ptr_q] = rlast_q;
            wr_ptr_d              = ~wr_ptr_q;
        end
        count_d = count_q + 2'(rvalid_q) - 2'(pop);
    end

    // Single state register; reset aborts any drain and discards in-flight data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            bank_q         <= 1'b0;
            len_q          <= '0;
            rd_cnt_q       <= '0;
            init_cnt_q     <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            rvalid_q       <= 1'b0;
            rlast_q        <= 1'b0;
            fifo_data_q[0] <= '0;
            fifo_data_q[1] <= '0;
            fifo_last_q    <= '0;
            wr_ptr_q       <= 1'b0;
            rd_ptr_q       <= 1'b0;
            count_q        <= '0;
        end else begin
            state_q        <= state_d;
            bank_q         <= bank_d;
            len_q          <= len_d;
            rd_cnt_q       <= rd_cnt_d;
            init_cnt_q     <= init_cnt_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            rvalid_q       <= rvalid_d;
            rlast_q        <= rlast_d;
            fifo_data_q[0] <= fifo_data_d[0];
            fifo_data_q[1] <= fifo_data_d[1];
            fifo_last_q    <= fifo_last_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
        end
    end
endmodule

// File: tb/tb_psum_gbf_drain.sv
// tb/tb_psum_gbf_drain.sv - directed self-checking bench for psum_gbf_drain
module tb_psum_gbf_drain;
    localparam int DW    = 512;
    localparam int AW    = 5;
    localparam int DEPTH = 32;
    localparam int LW    = AW + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          drain_start = 1'b0;
    logic          drain_bank = 1'b0;
    logic [LW-1:0] drain_len = '0;
    logic          busy, done;
    logic          psum_gbf_r_en;
    logic [AW-1:0] psum_gbf_r_addr;
    logic          psum_gbf_r_num;
    logic [DW-1:0] r_data1b, r_data2b;
    logic          psum_gbf_w_en_for_init;
    logic [AW-1:0] psum_gbf_w_addr_for_init;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          m_ready = 1'b1;
    logic          reload = 1'b0;

    logic [DW-1:0] mem1 [DEPTH];
    logic [DW-1:0] mem2 [DEPTH];

    int total = 0;
    int bad   = 0;

    logic [63:0] rd_q[$];
    logic [63:0] init_q[$];
    logic [63:0] beat_q[$];
    logic        last_q[$];
    int          rd_cyc_q[$];
    int          beat_cyc_q[$];
    int          done_cnt = 0;
    int          stab_err = 0;
    int          occ = 0;
    int          max_occ = 0;
    int          cyc = 0;
    logic        stall_prev = 1'b0;
    logic [DW-1:0] data_prev = '0;

    int s_rd, s_init, s_beat, s_done, s_stab;

    psum_gbf_drain #(
        .PSUM_GBF_DATA_BITWIDTH(DW),
        .PSUM_GBF_ADDR_BITWIDTH(AW),
        .PSUM_GBF_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .drain_start(drain_start),
        .drain_bank(drain_bank),
        .drain_len(drain_len),
        .busy(busy),
        .done(done),
        .psum_gbf_r_en(psum_gbf_r_en),
        .psum_gbf_r_addr(psum_gbf_r_addr),
        .psum_gbf_r_num(psum_gbf_r_num),
        .r_data1b(r_data1b),
        .r_data2b(r_data2b),
        .psum_gbf_w_en_for_init(psum_gbf_w_en_for_init),
        .psum_gbf_w_addr_for_init(psum_gbf_w_addr_for_init),
        .m_valid(m_valid),
        .m_data(m_data),
        .m_last(m_last),
        .m_ready(m_ready)
    );

    always #5 clk = ~clk;

    // Buffer model: bank1b entry k = k, bank2b entry k = 0x200 + k, 1-cycle read latency
    always @(posedge clk) begin
        if (reload) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem1[k] <= DW'(k);
                mem2[k] <= DW'(32'h200 + k);
            end
            r_data1b <= '0;
            r_data2b <= '0;
        end else begin
            if (psum_gbf_r_en) begin
                r_data1b <= mem1[psum_gbf_r_addr];
                r_data2b <= mem2[psum_gbf_r_addr];
            end
            if (psum_gbf_w_en_for_init) begin
                if (psum_gbf_r_num) mem2[psum_gbf_w_addr_for_init] <= '0;
                else                mem1[psum_gbf_w_addr_for_init] <= '0;
            end
        end
    end

    // Passive recorder sampled on the falling edge
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            occ        = 0;
            stall_prev = 1'b0;
        end else begin
            if (psum_gbf_r_en) begin
                rd_q.push_back(64'(psum_gbf_r_addr));
                rd_cyc_q.push_back(cyc);
                occ++;
            end
            if (psum_gbf_w_en_for_init) init_q.push_back(64'(psum_gbf_w_addr_for_init));
            if (m_valid && m_ready) begin
                beat_q.push_back(m_data[63:0]);
                beat_cyc_q.push_back(cyc);
                last_q.push_back(m_last);
                occ--;
            end
            if (occ > max_occ) max_occ = occ;
            if (done) done_cnt++;
            if (stall_prev && (!m_valid || m_data !== data_prev)) stab_err++;
            stall_prev = m_valid && !m_ready;
            data_prev  = m_data;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic snap();
        s_rd   = rd_q.size();
        s_init = init_q.size();
        s_beat = beat_q.size();
        s_done = done_cnt;
        s_stab = stab_err;
    endtask

    task automatic reload_mem();
        reload = 1'b1;
        step();
        reload = 1'b0;
    endtask

    task automatic start(input logic b, input int len);
        drain_start = 1'b1;
        drain_bank  = b;
        drain_len   = LW'(len);
        step();
        drain_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (done_cnt == s_done && n < budget) begin
            step();
            n++;
        end
        chk({tag, "_done_seen"}, 64'(done_cnt != s_done), 64'd1);
    endtask

    function automatic int beat_errs(input int base, input int n, input int first_val);
        int e = 0;
        for (int i = 0; i < n; i++) begin
            if (s_beat + i >= beat_q.size() || beat_q[s_beat + i] !== 64'(first_val + i)) e++;
        end
        return e + base;
    endfunction

    initial begin
        reload = 1'b1;
        #2;
        chk("reset_ctl", {57'd0, busy, done, psum_gbf_r_en, psum_gbf_r_num,
                          psum_gbf_w_en_for_init, m_valid, m_last}, 64'd0);
        chk("reset_addr", {54'd0, psum_gbf_r_addr, psum_gbf_w_addr_for_init}, 64'd0);
        chk("reset_mdata", 64'(m_data != '0), 64'd0);
        step();
        reload = 1'b0;
        step();
        rst = 1'b0;
        step();

        // Full drain of bank 0
        snap();
        m_ready = 1'b1;
        start(1'b0, 32);
        wait_done("full", 200);
        step();
        chk("full_busy_after", 64'(busy), 64'd0);
        chk("full_nreads", 64'(rd_q.size() - s_rd), 64'd32);
        chk("full_rd_consecutive", 64'(rd_cyc_q[s_rd + 31] - rd_cyc_q[s_rd]), 64'd31);
        chk("full_first_latency", 64'(beat_cyc_q[s_beat] - rd_cyc_q[s_rd]), 64'd2);
        chk("full_rd_last_addr", rd_q[s_rd + 31], 64'd31);
        chk("full_nbeats", 64'(beat_q.size() - s_beat), 64'd32);
        chk("full_data_errs", 64'(beat_errs(0, 32, 0)), 64'd0);
        begin
            int nl = 0;
            for (int i = s_beat; i < beat_q.size(); i++) nl += int'(last_q[i]);
            chk("full_nlast", 64'(nl), 64'd1);
        end
        chk("full_last_on_31", 64'(last_q[s_beat + 31]), 64'd1);
        chk("full_ninit", 64'(init_q.size() - s_init), 64'd32);
        begin
            int e = 0;
            for (int i = 0; i < 32; i++) if (init_q[s_init + i] !== 64'(i)) e++;
            chk("full_init_addr_errs", 64'(e), 64'd0);
            e = 0;
            for (int i = 0; i < DEPTH; i++) if (mem1[i] !== '0) e++;
            chk("full_bank0_zeroed", 64'(e), 64'd0);
        end
        for (int i = 0; i < 5; i++) step();
        chk("full_one_done", 64'(done_cnt - s_done), 64'd1);

        // Bank 1 with backpressure: ready high 1 cycle, low 2 cycles
        reload_mem();
        snap();
        start(1'b1, 8);
        begin
            int n = 0;
            while (done_cnt == s_done && n < 200) begin
                m_ready = (n % 3 == 0);
                step();
                n++;
            end
        end
        m_ready = 1'b1;
        chk("bp_done_seen", 64'(done_cnt != s_done), 64'd1);
        chk("bp_nbeats", 64'(beat_q.size() - s_beat), 64'd8);
        chk("bp_data_errs", 64'(beat_errs(0, 8, 32'h200)), 64'd0);
        chk("bp_last_on_7", 64'(last_q[s_beat + 7]), 64'd1);
        chk("bp_stable", 64'(stab_err - s_stab), 64'd0);
        chk("bp_max_outstanding", 64'(max_occ <= 2), 64'd1);

        // Zero length: done two cycles after the start cycle, nothing issued
        step();
        snap();
        start(1'b0, 0);
        chk("zero_busy_c1", {62'd0, busy, done}, 64'b10);
        step();
        chk("zero_done_c2", {62'd0, busy, done}, 64'b01);
        step();
        chk("zero_done_pulse", 64'(done), 64'd0);
        chk("zero_no_reads", 64'(rd_q.size() - s_rd), 64'd0);
        chk("zero_no_inits", 64'(init_q.size() - s_init), 64'd0);

        // Clamp: 40 behaves as 32
        reload_mem();
        snap();
        start(1'b0, 40);
        wait_done("clamp", 300);
        step();
        chk("clamp_nreads", 64'(rd_q.size() - s_rd), 64'd32);
        chk("clamp_ninit", 64'(init_q.size() - s_init), 64'd32);
        chk("clamp_nbeats", 64'(beat_q.size() - s_beat), 64'd32);
        chk("clamp_last_init", init_q[init_q.size() - 1], 64'd31);

        // Start while busy is ignored
        reload_mem();
        snap();
        start(1'b0, 16);
        step();
        step();
        start(1'b1, 4);
        wait_done("busy", 300);
        for (int i = 0; i < 10; i++) step();
        chk("busy_nbeats", 64'(beat_q.size() - s_beat), 64'd16);
        chk("busy_data_errs", 64'(beat_errs(0, 16, 0)), 64'd0);
        chk("busy_one_done", 64'(done_cnt - s_done), 64'd1);
        chk("busy_idle_after", 64'(busy), 64'd0);

        // Reset mid-drain, then a fresh short drain
        reload_mem();
        snap();
        start(1'b0, 16);
        begin
            int n = 0;
            while (beat_q.size() - s_beat < 5 && n < 100) begin
                step();
                n++;
            end
            chk("rst_reached_5_beats", 64'(beat_q.size() - s_beat >= 5), 64'd1);
        end
        rst = 1'b1;
        #1;
        chk("rst_mid_ctl", {57'd0, busy, done, psum_gbf_r_en, psum_gbf_r_num,
                            psum_gbf_w_en_for_init, m_valid, m_last}, 64'd0);
        chk("rst_mid_addr", {54'd0, psum_gbf_r_addr, psum_gbf_w_addr_for_init}, 64'd0);
        chk("rst_mid_mdata", 64'(m_data != '0), 64'd0);
        step();
        step();
        rst = 1'b0;
        step();
        snap();
        start(1'b0, 3);
        wait_done("post_rst", 100);
        step();
        chk("post_rst_nbeats", 64'(beat_q.size() - s_beat), 64'd3);
        chk("post_rst_first_addr", rd_q[s_rd], 64'd0);
        chk("post_rst_data_errs", 64'(beat_errs(0, 3, 0)), 64'd0);

        // Ready held low: only two reads, then everything flows once released
        reload_mem();
        snap();
        m_ready = 1'b0;
        start(1'b1, 16);
        for (int i = 0; i < 20; i++) step();
        chk("stall_nreads", 64'(rd_q.size() - s_rd), 64'd2);
        chk("stall_valid", 64'(m_valid), 64'd1);
        chk("stall_head", m_data[63:0], 64'h200);
        m_ready = 1'b1;
        wait_done("stall", 200);
        step();
        chk("stall_nbeats", 64'(beat_q.size() - s_beat), 64'd16);
        chk("stall_data_errs", 64'(beat_errs(0, 16, 32'h200)), 64'd0);
        chk("stall_stable", 64'(stab_err - s_stab), 64'd0);
        chk("stall_one_done", 64'(done_cnt - s_done), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
